action_executor: RTL and testbench

Pipeline stage directly downstream of the flow-table matcher. It takes the matcher's hit/miss result and flow value and interprets the value as one action record: NOP, SET_FIELD, DROP or DEC. It applies the action to a working copy of the packet header, writing one byte per cycle, then hands the modified header and a drop flag to the deparser with the same start/ready handshake the matcher uses.

---
 rtl/action_executor.sv | 169 ++++++++++++++++
 tb/tb_action_executor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_executor.sv
// rtl/action_executor.sv - applies one flow action (NOP/SET_FIELD/DROP/DEC) to a header copy; DEC gated by ACTION_EXECUTOR_DEC_EN
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 16
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif

module action_executor (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] pkt_hdr_i,
    input  logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0] parsed_hdrs_i,
    input  logic                                   is_match_i,
    input  logic [`MAX_VAL_LEN-1:0][`BYTE_BUS-1:0] flow_val_i,
    input  logic                                   mod_start_i,
    input  logic                                   mod_miss_drop_i,
    output logic                                   ready_o,
    output logic                                   drop_o,
    output logic                                   err_o,
    output logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] pkt_hdr_o
);
    localparam int IDX_W = $clog2(`HDR_MAX_LEN);
    localparam int DATA_LEN = `MAX_VAL_LEN - 4;
    localparam int DI_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [7:0] LEN_CAP = 8'(DATA_LEN);

    typedef enum logic [1:0] {FREE, DECODE, WRITE, DONE} state_t;
    state_t state, next_state;

    logic                                   miss_drop;
    logic                                   match_q;
    logic [7:0]                             op_q, hdr_id_q, off_q, len_q;
    logic [7:0]                             wlen, cnt, len_clamped;
    logic [DATA_LEN-1:0][`BYTE_BUS-1:0]     data_q;
    logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0] parsed_q;
    logic [31:0]                            tgt;
    logic [IDX_W-1:0]                       idx;
    logic                                   in_range;
    logic [`BYTE_BUS-1:0]                   wr_byte;
`ifdef ACTION_EXECUTOR_DEC_EN
    logic                                   dec_q;
    logic [`BYTE_BUS-1:0]                   orig_byte;
`endif

    always_comb begin
        len_clamped = (len_q > LEN_CAP) ? LEN_CAP : len_q;
        tgt         = 32'(parsed_q[hdr_id_q[3:0]]) + 32'(off_q) + 32'(cnt);
        in_range    = tgt < 32'(`HDR_MAX_LEN);
        idx         = tgt[IDX_W-1:0];
        wr_byte     = data_q[cnt[DI_W-1:0]];
`ifdef ACTION_EXECUTOR_DEC_EN
        orig_byte = pkt_hdr_o[idx];
        if (dec_q) begin
            wr_byte = (orig_byte == '0) ? '0 : orig_byte - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= next_state;
        end
    end

    // Non-writing outcomes pass through WRITE with length 0, so every
    // path reaches DONE exactly len+2 edges after the start is sampled.
    always_comb begin
        next_state = FREE;
        case (state)
            FREE:    next_state = (!mod_start_i && start_i) ? DECODE : FREE;
            DECODE:  next_state = WRITE;
            WRITE:   next_state = (cnt == wlen) ? DONE : WRITE;
            DONE:    next_state = start_i ? DONE : FREE;
            default: next_state = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o   <= 1'b0;
            drop_o    <= 1'b0;
            err_o     <= 1'b0;
            pkt_hdr_o <= '0;
            miss_drop <= 1'b0;
            cnt       <= '0;
            wlen      <= '0;
            match_q   <= 1'b0;
            op_q      <= '0;
            hdr_id_q  <= '0;
            off_q     <= '0;
            len_q     <= '0;
            data_q    <= '0;
            parsed_q  <= '0;
`ifdef ACTION_EXECUTOR_DEC_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            case (state)
                FREE: begin
                    if (mod_start_i) begin
                        miss_drop <= mod_miss_drop_i;
                    end else if (start_i) begin
                        pkt_hdr_o <= pkt_hdr_i;
                        parsed_q  <= parsed_hdrs_i;
                        match_q   <= is_match_i;
                        op_q      <= flow_val_i[0];
                        hdr_id_q  <= flow_val_i[1];
                        off_q     <= flow_val_i[2];
                        len_q     <= flow_val_i[3];
                        data_q    <= flow_val_i[`MAX_VAL_LEN-1:4];
                        ready_o   <= 1'b0;
                        drop_o    <= 1'b0;
                        err_o     <= 1'b0;
                        cnt       <= '0;
                    end
                end
                DECODE: begin
                    wlen <= '0;
`ifdef ACTION_EXECUTOR_DEC_EN
                    dec_q <= 1'b0;
`endif
                    if (!match_q) begin
                        drop_o <= miss_drop;
                    end else if (op_q == 8'd2) begin
                        drop_o <= 1'b1;
                    end else if (op_q == 8'd1) begin
                        wlen <= len_clamped;
`ifdef ACTION_EXECUTOR_DEC_EN
                    end else if (op_q == 8'd3) begin
                        wlen  <= 8'd1;
                        dec_q <= 1'b1;
`endif
                    end
                end
                WRITE: begin
                    if (cnt == wlen) begin
                        ready_o <= 1'b1;
                    end else begin
                        if (in_range) begin
                            pkt_hdr_o[idx] <= wr_byte;
                        end else begin
                            err_o <= 1'b1;
                        end
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        ready_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_action_executor.sv
// tb/tb_action_executor.sv - directed self-checking bench for action_executor
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 16
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif

module tb_action_executor;
    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] pkt_hdr_i;
    logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0] parsed_hdrs_i;
    logic is_match_i;
    logic [`MAX_VAL_LEN-1:0][`BYTE_BUS-1:0] flow_val_i;
    logic mod_start_i;
    logic mod_miss_drop_i;
    logic ready_o, drop_o, err_o;
    logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] pkt_hdr_o;

    logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] base_hdr, exp_hdr;
    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    action_executor dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(pkt_hdr_i),
        .parsed_hdrs_i(parsed_hdrs_i), .is_match_i(is_match_i),
        .flow_val_i(flow_val_i), .mod_start_i(mod_start_i),
        .mod_miss_drop_i(mod_miss_drop_i), .ready_o(ready_o), .drop_o(drop_o),
        .err_o(err_o), .pkt_hdr_o(pkt_hdr_o)
    );

    task automatic set_rec(input logic [7:0] op, input logic [7:0] hid,
                           input logic [7:0] off, input logic [7:0] len);
        flow_val_i = '0;
        flow_val_i[0] = op;
        flow_val_i[1] = hid;
        flow_val_i[2] = off;
        flow_val_i[3] = len;
    endtask

    // lat = edges after E0 at which ready_o is first seen high; -1 on timeout
    task automatic run_request(input logic match, input int mod_at, output int l);
        @(negedge clk);
        mod_start_i = 1'b0;
        is_match_i = match;
        start_i = 1'b1;
        l = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == mod_at) begin
                mod_start_i = 1'b1;
                mod_miss_drop_i = 1'b1;
            end else begin
                mod_start_i = 1'b0;
            end
            if (ready_o) begin
                l = k;
                break;
            end
        end
        mod_start_i = 1'b0;
    endtask

    task automatic release_req;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic config_miss(input logic v);
        @(negedge clk);
        mod_start_i = 1'b1;
        mod_miss_drop_i = v;
        @(negedge clk);
        mod_start_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_i = 1'b1;
        is_match_i = 1'b1;
        set_rec(8'd1, 8'd2, 8'd0, 8'd4);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready_o, drop_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {ready_o, drop_o, err_o});
        end
        checks++;
        if (pkt_hdr_o !== '0) begin
            errors++;
            $display("FAIL reset_hdr got %h exp 0", pkt_hdr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready got %b exp 0", ready_o);
        end
    endtask

    task automatic test_set_field;
        pkt_hdr_i = base_hdr;
        set_rec(8'd1, 8'd2, 8'd2, 8'd4);
        flow_val_i[4] = 8'hDE; flow_val_i[5] = 8'hAD;
        flow_val_i[6] = 8'hBE; flow_val_i[7] = 8'hEF;
        exp_hdr = base_hdr;
        exp_hdr[16] = 8'hDE; exp_hdr[17] = 8'hAD;
        exp_hdr[18] = 8'hBE; exp_hdr[19] = 8'hEF;
        run_request(1'b1, -1, lat);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL set_latency got %0d exp 6", lat); end
        checks++;
        if (pkt_hdr_o !== exp_hdr) begin
            errors++;
            $display("FAIL set_hdr got %h exp %h", pkt_hdr_o, exp_hdr);
        end
        checks++;
        if ({drop_o, err_o} !== 2'b00) begin
            errors++;
            $display("FAIL set_flags got %b exp 00", {drop_o, err_o});
        end
        release_req();
    endtask

    task automatic test_miss;
        pkt_hdr_i = base_hdr;
        set_rec(8'd1, 8'd2, 8'd0, 8'd4);
        flow_val_i[4] = 8'h55;
        // configuration and start together: config is taken, request waits
        @(negedge clk);
        mod_start_i = 1'b1;
        mod_miss_drop_i = 1'b1;
        is_match_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL miss_cfg_ready got %b exp 0", ready_o); end
        run_request(1'b0, -1, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL miss1_latency got %0d exp 2", lat); end
        checks++;
        if (drop_o !== 1'b1) begin errors++; $display("FAIL miss1_drop got %b exp 1", drop_o); end
        checks++;
        if (pkt_hdr_o !== base_hdr) begin
            errors++;
            $display("FAIL miss1_hdr got %h exp %h", pkt_hdr_o, base_hdr);
        end
        release_req();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL miss1_release got %b exp 0", ready_o); end
        config_miss(1'b0);
        run_request(1'b0, -1, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL miss0_latency got %0d exp 2", lat); end
        checks++;
        if (drop_o !== 1'b0) begin errors++; $display("FAIL miss0_drop got %b exp 0", drop_o); end
        checks++;
        if (pkt_hdr_o !== base_hdr) begin
            errors++;
            $display("FAIL miss0_hdr got %h exp %h", pkt_hdr_o, base_hdr);
        end
        release_req();
    endtask

    task automatic test_dec;
        logic [7:0] vin [2];
        logic [7:0] vexp [2];
        int exp_lat;
        vin[0] = 8'h40;
        vin[1] = 8'h00;
`ifdef ACTION_EXECUTOR_DEC_EN
        vexp[0] = 8'h3F;
        vexp[1] = 8'h00;
        exp_lat = 3;
`else
        vexp[0] = 8'h40;
        vexp[1] = 8'h00;
        exp_lat = 2;
`endif
        for (int n = 0; n < 2; n++) begin
            pkt_hdr_i = base_hdr;
            pkt_hdr_i[22] = vin[n];
            set_rec(8'd3, 8'd2, 8'd8, 8'd0);
            exp_hdr = base_hdr;
            exp_hdr[22] = vexp[n];
            run_request(1'b1, -1, lat);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL dec%0d_latency got %0d exp %0d", n, lat, exp_lat);
            end
            checks++;
            if (pkt_hdr_o !== exp_hdr) begin
                errors++;
                $display("FAIL dec%0d_hdr got %h exp %h", n, pkt_hdr_o, exp_hdr);
            end
            release_req();
        end
    endtask

    task automatic test_err;
        pkt_hdr_i = base_hdr;
        set_rec(8'd1, 8'd2, 8'd46, 8'd6);
        for (int i = 0; i < 6; i++) flow_val_i[4+i] = 8'(8'h11 + i);
        exp_hdr = base_hdr;
        exp_hdr[60] = 8'h11; exp_hdr[61] = 8'h12;
        exp_hdr[62] = 8'h13; exp_hdr[63] = 8'h14;
        run_request(1'b1, -1, lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL err_latency got %0d exp 8", lat); end
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", err_o); end
        checks++;
        if (pkt_hdr_o !== exp_hdr) begin
            errors++;
            $display("FAIL err_hdr got %h exp %h", pkt_hdr_o, exp_hdr);
        end
        release_req();
    endtask

    task automatic test_back_to_back;
        int bad;
        pkt_hdr_i = base_hdr;
        set_rec(8'd1, 8'd2, 8'd0, 8'd4);
        flow_val_i[4] = 8'hA1; flow_val_i[5] = 8'hA2;
        flow_val_i[6] = 8'hA3; flow_val_i[7] = 8'hA4;
        exp_hdr = base_hdr;
        exp_hdr[14] = 8'hA1; exp_hdr[15] = 8'hA2;
        exp_hdr[16] = 8'hA3; exp_hdr[17] = 8'hA4;
        // mod_start_i pulsed while in WRITE must not change miss_drop
        run_request(1'b1, 2, lat);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL b2b_latency got %0d exp 6", lat); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pkt_hdr_i = '1;
            flow_val_i = '1;
            if (ready_o !== 1'b1 || drop_o !== 1'b0 || err_o !== 1'b0 || pkt_hdr_o !== exp_hdr) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL done_hold got %0d unstable cycles exp 0", bad);
        end
        release_req();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_release got %b exp 0", ready_o); end
        pkt_hdr_i = base_hdr;
        set_rec(8'd2, 8'd2, 8'd0, 8'd0);
        run_request(1'b1, -1, lat);
        checks++;
        if (lat !== 2 || drop_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_req got lat %0d drop %b exp lat 2 drop 1", lat, drop_o);
        end
        checks++;
        if (pkt_hdr_o !== base_hdr) begin
            errors++;
            $display("FAIL drop_hdr got %h exp %h", pkt_hdr_o, base_hdr);
        end
        release_req();
        run_request(1'b0, -1, lat);
        checks++;
        if (lat !== 2 || drop_o !== 1'b0) begin
            errors++;
            $display("FAIL mod_ignored got lat %0d drop %b exp lat 2 drop 0", lat, drop_o);
        end
        release_req();
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        is_match_i = 1'b0;
        mod_start_i = 1'b0;
        mod_miss_drop_i = 1'b0;
        flow_val_i = '0;
        parsed_hdrs_i = '0;
        parsed_hdrs_i[1] = 32'd6;
        parsed_hdrs_i[2] = 32'd14;
        parsed_hdrs_i[3] = 32'd34;
        for (int i = 0; i < `HDR_MAX_LEN; i++) base_hdr[i] = 8'(i * 7 + 3);
        pkt_hdr_i = base_hdr;
        exp_hdr = base_hdr;

        test_reset();
        test_set_field();
        test_miss();
        test_dec();
        test_err();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
